// File: rtl/sbox_layer_ctrl.sv
// Sequencer for one masked S-box layer: issues nibbles to a shared, non-stallable
// S-box pipeline of depth LAT and tracks their write-back through a valid/index shift register.
module sbox_layer_ctrl #(
    parameter int LAT  = 4,
    parameter int NNIB = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_rnd_valid,
    output logic       o_rnd_req,
    output logic       o_sbox_en,
    output logic [3:0] o_sel_idx,
    output logic       o_wr_en,
    output logic [3:0] o_wr_idx,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [3:0]     LAST_IDX = 4'(NNIB - 1);
    localparam logic [LAT-1:0] VLD_TOP  = LAT'(1) << (LAT - 1);

    state_t         r_state;
    state_t         w_next;
    logic [LAT-1:0] r_vld;
    logic [3:0]     r_idx [LAT];
    logic [3:0]     r_issue_cnt;
    logic           r_err;

    logic w_issue;
    logic w_flush;
    logic w_clear;
    logic w_set_err;
    logic w_inflight;
    logic w_tail_empty;

    // The write-back stage still counts as in flight; the layer is drained once only it remains.
    assign w_inflight   = |r_vld;
    assign w_tail_empty = ((r_vld & ~VLD_TOP) == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_issue   = 1'b0;
        w_flush   = 1'b0;
        w_clear   = 1'b0;
        w_set_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    w_next  = S_RUN;
                    w_clear = 1'b1;
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    w_next  = S_IDLE;
                    w_flush = 1'b1;
                end else if (i_rnd_valid) begin
                    w_issue = 1'b1;
                    if (r_issue_cnt == LAST_IDX) begin
                        w_next = S_DRAIN;
                    end
                end else if (w_inflight) begin
                    // Downstream S-box registers cannot stall, so missing randomness corrupts the layer.
                    w_next    = S_ERR;
                    w_flush   = 1'b1;
                    w_set_err = 1'b1;
                end
            end
            S_DRAIN: begin
                if (i_abort) begin
                    w_next  = S_IDLE;
                    w_flush = 1'b1;
                end else if (!i_rnd_valid) begin
                    w_next    = S_ERR;
                    w_flush   = 1'b1;
                    w_set_err = 1'b1;
                end else if (w_tail_empty) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            S_ERR: begin
                w_flush = 1'b1;
                if (i_abort || i_start) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next  = S_IDLE;
                w_flush = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_issue_cnt <= 4'd0;
            r_vld       <= '0;
            r_err       <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                r_idx[i] <= 4'd0;
            end
        end else begin
            if (w_clear) begin
                r_issue_cnt <= 4'd0;
            end else if (w_issue) begin
                r_issue_cnt <= (r_issue_cnt == LAST_IDX) ? 4'd0 : r_issue_cnt + 4'd1;
            end

            if (w_flush || w_clear) begin
                r_vld <= '0;
            end else begin
                r_vld[0] <= w_issue;
                for (int i = 1; i < LAT; i++) begin
                    r_vld[i] <= r_vld[i-1];
                end
            end

            r_idx[0] <= r_issue_cnt;
            for (int i = 1; i < LAT; i++) begin
                r_idx[i] <= r_idx[i-1];
            end

            if (w_clear) begin
                r_err <= 1'b0;
            end else if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_sbox_en = w_issue;
    assign o_sel_idx = r_issue_cnt;
    assign o_wr_en   = r_vld[LAT-1] && (r_state != S_ERR);
    assign o_wr_idx  = r_idx[LAT-1];
    assign o_rnd_req = w_issue | w_inflight;
    assign o_busy    = (r_state == S_RUN) || (r_state == S_DRAIN) || (r_state == S_DONE);
    assign o_done    = (r_state == S_DONE);
    assign o_err     = r_err;

endmodule

// File: tb/tb_sbox_layer_ctrl.sv
// Directed bench for sbox_layer_ctrl: default instance (LAT=4, NNIB=16) and a small one (LAT=2, NNIB=4).
module tb_sbox_layer_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstN;
    logic       startA, abortA, rndA;
    logic       rndReqA, sboxEnA, wrEnA, busyA, doneA, errA;
    logic [3:0] selIdxA, wrIdxA;
    logic       startB, abortB, rndB;
    logic       rndReqB, sboxEnB, wrEnB, busyB, doneB, errB;
    logic [3:0] selIdxB, wrIdxB;

    int nCompared = 0;
    int nMismatch = 0;

    sbox_layer_ctrl dutA (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_start     (startA),
        .i_abort     (abortA),
        .i_rnd_valid (rndA),
        .o_rnd_req   (rndReqA),
        .o_sbox_en   (sboxEnA),
        .o_sel_idx   (selIdxA),
        .o_wr_en     (wrEnA),
        .o_wr_idx    (wrIdxA),
        .o_busy      (busyA),
        .o_done      (doneA),
        .o_err       (errA)
    );

    sbox_layer_ctrl #(.LAT(2), .NNIB(4)) dutB (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_start     (startB),
        .i_abort     (abortB),
        .i_rnd_valid (rndB),
        .o_rnd_req   (rndReqB),
        .o_sbox_en   (sboxEnB),
        .o_sel_idx   (selIdxB),
        .o_wr_en     (wrEnB),
        .o_wr_idx    (wrIdxB),
        .o_busy      (busyB),
        .o_done      (doneB),
        .o_err       (errB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected)
        else begin
            nMismatch++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic dutSel, input logic s, input logic a, input logic r);
        if (!dutSel) begin
            startA = s;
            abortA = a;
            rndA   = r;
        end else begin
            startB = s;
            abortB = a;
            rndB   = r;
        end
        #2;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Expected waveform of an unstalled-after-first-issue layer: first issue in cycle f.
    task automatic checkLayerCycle(input logic dutSel, input int c, input int f, input int n,
                                   input int l, input string name);
        logic       sb, wr, bz, dn, er, rq;
        logic [3:0] si, wi;
        logic       eSb, eWr, eBz, eDn, eRq;
        sb = dutSel ? sboxEnB : sboxEnA;
        wr = dutSel ? wrEnB   : wrEnA;
        bz = dutSel ? busyB   : busyA;
        dn = dutSel ? doneB   : doneA;
        er = dutSel ? errB    : errA;
        rq = dutSel ? rndReqB : rndReqA;
        si = dutSel ? selIdxB : selIdxA;
        wi = dutSel ? wrIdxB  : wrIdxA;
        eSb = (c >= f) && (c <= f + n - 1);
        eWr = (c >= f + l) && (c <= f + l + n - 1);
        eDn = (c == f + l + n);
        eBz = (c >= 1) && (c <= f + l + n);
        eRq = (c >= f) && (c <= f + l + n - 1);
        checkOutput($sformatf("%s c%0d sbox_en", name, c), 32'(sb), 32'(eSb));
        checkOutput($sformatf("%s c%0d wr_en", name, c), 32'(wr), 32'(eWr));
        checkOutput($sformatf("%s c%0d done", name, c), 32'(dn), 32'(eDn));
        checkOutput($sformatf("%s c%0d busy", name, c), 32'(bz), 32'(eBz));
        checkOutput($sformatf("%s c%0d rnd_req", name, c), 32'(rq), 32'(eRq));
        checkOutput($sformatf("%s c%0d err", name, c), 32'(er), 32'd0);
        if (eSb) checkOutput($sformatf("%s c%0d sel_idx", name, c), 32'(si), 32'(c - f));
        if (eWr) checkOutput($sformatf("%s c%0d wr_idx", name, c), 32'(wi), 32'(c - f - l));
    endtask

    task automatic checkAllZeroA(input string name);
        checkOutput({name, " sbox_en"}, 32'(sboxEnA), 32'd0);
        checkOutput({name, " wr_en"},   32'(wrEnA),   32'd0);
        checkOutput({name, " rnd_req"}, 32'(rndReqA), 32'd0);
        checkOutput({name, " busy"},    32'(busyA),   32'd0);
        checkOutput({name, " done"},    32'(doneA),   32'd0);
        checkOutput({name, " err"},     32'(errA),    32'd0);
        checkOutput({name, " sel_idx"}, 32'(selIdxA), 32'd0);
        checkOutput({name, " wr_idx"},  32'(wrIdxA),  32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic seen;
        rstN = 1'b0;
        startA = 1'b0; abortA = 1'b0; rndA = 1'b0;
        startB = 1'b0; abortB = 1'b0; rndB = 1'b0;

        // Reset state
        nextCycle();
        nextCycle();
        checkAllZeroA("reset A");
        checkOutput("reset B busy", 32'(busyB), 32'd0);
        checkOutput("reset B sel_idx", 32'(selIdxB), 32'd0);
        rstN = 1'b1;
        nextCycle();
        applyStimulus(0, 0, 0, 1);
        checkAllZeroA("idle A");

        // Nominal layer
        applyStimulus(0, 1, 0, 1);
        for (int c = 1; c <= 22; c++) begin
            nextCycle();
            applyStimulus(0, 0, 0, 1);
            checkLayerCycle(0, c, 1, 16, 4, "nominal");
        end

        // Initial randomness stall
        nextCycle();
        applyStimulus(0, 1, 0, 0);
        for (int c = 1; c <= 25; c++) begin
            nextCycle();
            applyStimulus(0, 0, 0, (c >= 4));
            checkLayerCycle(0, c, 4, 16, 4, "stall");
        end

        // Starvation with nibbles in flight
        nextCycle();
        applyStimulus(0, 1, 0, 1);
        for (int c = 1; c <= 5; c++) begin
            nextCycle();
            applyStimulus(0, 0, 0, 1);
            checkLayerCycle(0, c, 1, 16, 4, "starve");
        end
        nextCycle();
        applyStimulus(0, 0, 0, 0);
        checkOutput("starve c6 sbox_en", 32'(sboxEnA), 32'd0);
        checkOutput("starve c6 wr_en", 32'(wrEnA), 32'd1);
        checkOutput("starve c6 wr_idx", 32'(wrIdxA), 32'd1);
        checkOutput("starve c6 err", 32'(errA), 32'd0);
        for (int c = 7; c <= 9; c++) begin
            nextCycle();
            applyStimulus(0, 0, 0, 1);
            checkOutput($sformatf("starve c%0d err", c), 32'(errA), 32'd1);
            checkOutput($sformatf("starve c%0d busy", c), 32'(busyA), 32'd0);
            checkOutput($sformatf("starve c%0d wr_en", c), 32'(wrEnA), 32'd0);
            checkOutput($sformatf("starve c%0d sbox_en", c), 32'(sboxEnA), 32'd0);
            checkOutput($sformatf("starve c%0d rnd_req", c), 32'(rndReqA), 32'd0);
        end
        nextCycle();
        applyStimulus(0, 1, 0, 1);
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            nextCycle();
            applyStimulus(0, (k == 0), 0, 1);
            if (sboxEnA) begin
                seen = 1'b1;
                checkOutput("restart sel_idx", 32'(selIdxA), 32'd0);
                checkOutput("restart err", 32'(errA), 32'd0);
                checkOutput("restart busy", 32'(busyA), 32'd1);
            end
        end
        checkOutput("restart sbox_en seen", 32'(seen), 32'd1);
        nextCycle();
        applyStimulus(0, 0, 1, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 1);
        checkOutput("post-abort busy", 32'(busyA), 32'd0);

        // Abort and start together
        nextCycle();
        applyStimulus(0, 1, 0, 1);
        for (int c = 1; c <= 7; c++) begin
            nextCycle();
            applyStimulus(0, 0, 0, 1);
            checkLayerCycle(0, c, 1, 16, 4, "abort");
        end
        nextCycle();
        applyStimulus(0, 1, 1, 1);
        for (int c = 9; c <= 30; c++) begin
            nextCycle();
            applyStimulus(0, 0, 0, 1);
            checkOutput($sformatf("abort c%0d wr_en", c), 32'(wrEnA), 32'd0);
            checkOutput($sformatf("abort c%0d done", c), 32'(doneA), 32'd0);
            checkOutput($sformatf("abort c%0d busy", c), 32'(busyA), 32'd0);
            checkOutput($sformatf("abort c%0d sbox_en", c), 32'(sboxEnA), 32'd0);
        end

        // Asynchronous reset during drain
        nextCycle();
        applyStimulus(0, 1, 0, 1);
        for (int c = 1; c <= 18; c++) begin
            nextCycle();
            applyStimulus(0, 0, 0, 1);
            checkLayerCycle(0, c, 1, 16, 4, "rstdrain");
        end
        #1 rstN = 1'b0;
        #1 checkAllZeroA("async reset");
        #2 rstN = 1'b1;
        for (int c = 19; c <= 40; c++) begin
            nextCycle();
            applyStimulus(0, 0, 0, 1);
            checkOutput($sformatf("rstdrain c%0d wr_en", c), 32'(wrEnA), 32'd0);
            checkOutput($sformatf("rstdrain c%0d busy", c), 32'(busyA), 32'd0);
        end

        // Small instance: LAT=2, NNIB=4
        nextCycle();
        applyStimulus(1, 1, 0, 1);
        for (int c = 1; c <= 8; c++) begin
            nextCycle();
            applyStimulus(1, 0, 0, 1);
            checkLayerCycle(1, c, 1, 4, 2, "small");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
